// File: rtl/hilo_if.sv
// Core-facing and multiplier-facing signals of the HI/LO issue/writeback stage.
interface hilo_if;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        mfhi;
    logic        mflo;
    logic [31:0] rdata;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    // Seen from the HI/LO unit
    modport slave (
        input  start, is_signed, op_a, op_b, mthi, mtlo, wdata, mfhi, mflo,
               mul_hi, mul_lo,
        output rdata, mul_a, mul_b, hi, lo, busy, stall, done
    );

    // Seen from the core / multiplier side
    modport master (
        output start, is_signed, op_a, op_b, mthi, mtlo, wdata, mfhi, mflo,
               mul_hi, mul_lo,
        input  rdata, mul_a, mul_b, hi, lo, busy, stall, done
    );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO issue/writeback stage around an external pipelined 32x32 unsigned
// multiplier: feeds operand magnitudes, waits MUL_LATENCY edges, then
// sign-corrects the product into HI/LO. Also handles MTHI/MTLO/MFHI/MFLO.
module hilo_unit #(
    parameter int MUL_LATENCY = 2
) (
    input  logic   clock,
    input  logic   reset,
    hilo_if.slave  bus
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        neg;
    logic [31:0] mul_a_q, mul_b_q, hi_q, lo_q;
    logic        done_q;
    logic        accept;
    logic        last;

    // A start is only taken from IDLE; last marks the writeback edge.
    assign accept = (state == IDLE) && bus.start;
    assign last   = (state == WAIT) && (cnt == 4'd1);

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, latency count, HI/LO writeback and move-to writes
    always_ff @(posedge clock) begin
        if (reset) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
            neg     <= 1'b0;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                // 0x80000000 negates to itself, which is the right magnitude
                mul_a_q <= (bus.is_signed && bus.op_a[31]) ? -bus.op_a : bus.op_a;
                mul_b_q <= (bus.is_signed && bus.op_b[31]) ? -bus.op_b : bus.op_b;
                neg     <= bus.is_signed & (bus.op_a[31] ^ bus.op_b[31]);
                cnt     <= 4'(MUL_LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1)
                    {hi_q, lo_q} <= neg ? -{bus.mul_hi, bus.mul_lo}
                                        :  {bus.mul_hi, bus.mul_lo};
            end else begin
                if (bus.mthi) hi_q <= bus.wdata;
                if (bus.mtlo) lo_q <= bus.wdata;
            end
        end
    end

    // Status outputs and move-from read port
    always_comb begin
        bus.busy  = (state == WAIT);
        bus.stall = (state == WAIT) &
                    (bus.start | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo);
        bus.rdata = '0;
        if (!bus.stall) begin
            if (bus.mfhi)      bus.rdata = hi_q;
            else if (bus.mflo) bus.rdata = lo_q;
        end
    end

    assign bus.mul_a = mul_a_q;
    assign bus.mul_b = mul_b_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: table vectors, random multiplies against an
// arithmetic product model, and hand sequences for hazards and reset.
module tb_hilo_unit;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    hilo_if bus();

    hilo_unit #(.MUL_LATENCY(LAT)) dut (.clock(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    // One-register-stage unsigned multiplier; garble replaces its output with noise
    logic [63:0] prod, junk;
    logic        garble = 1'b0;
    always @(posedge clk) begin
        prod <= {32'b0, bus.mul_a} * {32'b0, bus.mul_b};
        junk <= {$urandom, $urandom};
    end
    assign bus.mul_hi = garble ? junk[63:32] : prod[63:32];
    assign bus.mul_lo = garble ? junk[31:0]  : prod[31:0];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: full-width product from sign- or zero-extended operands
    function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] ref_mag(input logic sgn, input logic [31:0] v);
        return (sgn && v[31]) ? 32'(0 - v) : v;
    endfunction

    // Issue one multiply and check operands, busy length, single done and result
    task automatic run_mult(input string tag, input logic sgn, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] xma,
                            input logic [31:0] xmb, input logic [63:0] xp, input bit mv);
        int busy_n = 0;
        int done_n = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = sgn; bus.op_a = a; bus.op_b = b;
        if (mv) begin bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hAAAA5555; end
        @(negedge clk);
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        chk({tag, " mul_a"}, 64'(bus.mul_a), 64'(xma));
        chk({tag, " mul_b"}, 64'(bus.mul_b), 64'(xmb));
        for (int k = 0; k < LAT + 4; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (done_n == 1) chk({tag, " hilo"}, {bus.hi, bus.lo}, xp);
            end
        end
        chk({tag, " busy cycles"}, 64'(busy_n), 64'(LAT));
        chk({tag, " done pulses"}, 64'(done_n), 64'd1);
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] a, b, ma, mb;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          guard;

        vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[1] = '{1'b1, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA};
        vecs[2] = '{1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
        vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 64'h00000000_00000001};
        vecs[4] = '{1'b0, 32'h80000000, 32'h00000002, 32'h80000000, 32'h00000002, 64'h00000001_00000000};
        vecs[5] = '{1'b1, 32'h00000005, 32'hFFFFFFF9, 32'h00000005, 32'h00000007, 64'hFFFFFFFF_FFFFFFDD};

        bus.start = 0; bus.is_signed = 0; bus.op_a = 0; bus.op_b = 0;
        bus.mthi = 0; bus.mtlo = 0; bus.wdata = 0; bus.mfhi = 0; bus.mflo = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset hilo", {bus.hi, bus.lo}, 64'd0);
        chk("reset mul_ab", {bus.mul_a, bus.mul_b}, 64'd0);
        chk("reset busy/done/stall", {61'd0, bus.busy, bus.done, bus.stall}, 64'd0);

        // Move-to / move-from; a same-cycle read sees the old value
        bus.mthi = 1; bus.mtlo = 1; bus.wdata = 32'h12345678; bus.mfhi = 1;
        #1 chk("mf same-cycle old", 64'(bus.rdata), 64'd0);
        @(negedge clk);
        bus.mthi = 0; bus.mtlo = 0; bus.mfhi = 1; bus.mflo = 1;
        chk("mt hilo", {bus.hi, bus.lo}, 64'h12345678_12345678);
        #1 chk("mfhi priority", 64'(bus.rdata), 64'h12345678);
        chk("idle no stall", 64'(bus.stall), 64'd0);
        bus.mtlo = 1; bus.wdata = 32'h0BADF00D; bus.mfhi = 0;
        @(negedge clk);
        bus.mtlo = 0;
        #1 chk("mflo", 64'(bus.rdata), 64'h0BADF00D);
        chk("mtlo keeps hi", 64'(bus.hi), 64'h12345678);
        bus.mflo = 0;

        // Table vectors
        for (int i = 0; i < 6; i++)
            run_mult($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                     vecs[i].ma, vecs[i].mb, vecs[i].p, 1'b0);

        // Randomized multiplies, with corner operands mixed in
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: a = 32'hFFFFFFFF;
                2: a = 32'h0;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            run_mult($sformatf("rnd%0d", i), s, a, b, ref_mag(s, a), ref_mag(s, b),
                     ref_prod(s, a, b), 1'b0);
        end

        // start together with move-to in IDLE: start wins
        run_mult("start+mt", 1'b0, 32'd3, 32'd4, 32'd3, 32'd4, 64'd12, 1'b1);

        // Hazard: mfhi while busy stalls and reads 0; reads new hi once idle
        @(negedge clk);
        bus.start = 1; bus.is_signed = 1; bus.op_a = 32'hFFFFFFFE; bus.op_b = 32'd3;
        @(negedge clk);
        bus.start = 0; bus.mfhi = 1;
        #1 chk("hazard stall", 64'(bus.stall), 64'd1);
        chk("hazard rdata", 64'(bus.rdata), 64'd0);
        guard = 0;
        while (bus.busy && guard < 20) begin @(negedge clk); guard++; end
        chk("hazard timeout", 64'(bus.busy), 64'd0);
        #1 chk("hazard release stall", 64'(bus.stall), 64'd0);
        chk("hazard release rdata", 64'(bus.rdata), 64'hFFFFFFFF);
        bus.mfhi = 0;

        // Move-to while busy is ignored
        @(negedge clk);
        bus.start = 1; bus.is_signed = 1; bus.op_a = 32'd5; bus.op_b = 32'hFFFFFFF9;
        @(negedge clk);
        bus.start = 0; bus.mthi = 1; bus.mtlo = 1; bus.wdata = 32'hDEADBEEF;
        #1 chk("mt busy stall", 64'(bus.stall), 64'd1);
        guard = 0;
        while (bus.busy && guard < 20) begin @(negedge clk); guard++; end
        bus.mthi = 0; bus.mtlo = 0;
        chk("mt busy timeout", 64'(bus.busy), 64'd0);
        chk("mt busy ignored", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFDD);

        // Reset during WAIT: no writeback, no done, multiplier output ignored
        @(negedge clk);
        bus.start = 1; bus.is_signed = 0; bus.op_a = 32'hFFFFFFFF; bus.op_b = 32'h7;
        @(negedge clk);
        bus.start = 0; rst = 1;
        @(negedge clk);
        chk("rst mid busy", 64'(bus.busy), 64'd0);
        chk("rst mid hilo", {bus.hi, bus.lo}, 64'd0);
        chk("rst mid mul_a", 64'(bus.mul_a), 64'd0);
        rst = 0; garble = 1;
        guard = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done) guard++;
        end
        garble = 0;
        chk("rst mid done", 64'(guard), 64'd0);
        chk("rst mid hilo later", {bus.hi, bus.lo}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
